// File: rtl/bit_serial_cmp_ctrl.sv
// Bit-serial magnitude comparator controller: one comparator slice reused MSB-first over WIDTH cycles.
// Optional build macro CMP_EARLY_EXIT_EN ends the compare at the first differing bit.
module bit_serial_cmp_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             eq,
   output logic             gt,
   output logic             lt
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPARE = 2'd1,
      DONE    = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   logic [CNT_W-1:0] cnt;
   logic             e_r;
   logic             g_r;
   logic             e1;
   logic             g1;
   logic             last_bit;

   function automatic logic slice_eq(input logic e0, input logic ai, input logic bi);
      return e0 & ~(ai ^ bi);
   endfunction

   function automatic logic slice_gt(input logic e0, input logic g0, input logic ai, input logic bi);
      return g0 | (e0 & ai & ~bi);
   endfunction

   always_comb begin
      e1 = slice_eq(e_r, sa[cnt], sb[cnt]);
      g1 = slice_gt(e_r, g_r, sa[cnt], sb[cnt]);
`ifdef CMP_EARLY_EXIT_EN
      // Once the chain is unequal, later bits cannot alter the result.
      last_bit = (cnt == '0) || !e1;
`else
      last_bit = (cnt == '0);
`endif
   end

   // Operand copies are pure data and need no reset.
   always_ff @(posedge clk) begin
      if (state == IDLE && start) begin
         sa <= a;
         sb <= b;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         eq    <= 1'b0;
         gt    <= 1'b0;
         lt    <= 1'b0;
         e_r   <= 1'b1;
         g_r   <= 1'b0;
         cnt   <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  cnt   <= CNT_W'(WIDTH - 1);
                  e_r   <= 1'b1;
                  g_r   <= 1'b0;
                  busy  <= 1'b1;
                  state <= COMPARE;
               end
            end
            COMPARE: begin
               e_r <= e1;
               g_r <= g1;
               if (last_bit) begin
                  busy  <= 1'b0;
                  state <= DONE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            DONE: begin
               // e_r/g_r hold the slice outputs of the last processed bit.
               eq    <= e_r;
               gt    <= g_r;
               lt    <= ~e_r & ~g_r;
               done  <= 1'b1;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bit_serial_cmp_ctrl.sv
// Self-checking bench for bit_serial_cmp_ctrl: directed cases plus random operands against a
// plain-arithmetic reference (relation from integer compare, latency from leading-equal-bit count).
module tb_bit_serial_cmp_ctrl;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic             eq;
   logic             gt;
   logic             lt;

   int tests = 0;
   int fails = 0;

   bit_serial_cmp_ctrl #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .eq    (eq),
      .gt    (gt),
      .lt    (lt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Cycles from the accepting edge to the cycle in which done is visible.
   function automatic int exp_lat(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
`ifdef CMP_EARLY_EXIT_EN
      int k;
      k = 0;
      if (x == y) return WIDTH + 1;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (x[i] != y[i]) break;
         k++;
      end
      return k + 2;
`else
      return (x == y) ? WIDTH + 1 : WIDTH + 1;
`endif
   endfunction

   task automatic run(input string tag, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                      input bit perturb);
      int lat;
      int bn;
      int el;
      lat = -1;
      bn  = 0;
      @(negedge clk);
      a     = x;
      b     = y;
      start = 1'b1;
      @(posedge clk);
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (n == 0) begin
            start = 1'b0;
            if (perturb) begin
               a = 8'hFF;
               b = 8'h00;
            end
         end
         if (perturb && n == 2) start = 1'b1;
         if (perturb && n == 3) start = 1'b0;
         if (busy) bn++;
         if (done) begin
            lat = n;
            break;
         end
      end
      el = exp_lat(x, y);
      chk({tag, "_latency"}, lat, el);
      chk({tag, "_busy_cycles"}, bn, el - 1);
      chk({tag, "_result"}, {29'd0, eq, gt, lt}, {29'd0, x == y, x > y, x < y});
      @(negedge clk);
      chk({tag, "_done_single"}, {31'd0, done}, 32'd0);
      chk({tag, "_result_hold"}, {29'd0, eq, gt, lt}, {29'd0, x == y, x > y, x < y});
      if (perturb) begin
         int extra;
         extra = 0;
         for (int n = 0; n < WIDTH + 4; n++) begin
            @(negedge clk);
            if (done || busy) extra++;
         end
         chk({tag, "_ignored_start"}, extra, 0);
      end
   endtask

   initial begin
      int seen;
      int first;
      int second;
      logic [WIDTH-1:0] x;
      logic [WIDTH-1:0] y;

      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("reset_outputs", {27'd0, busy, done, eq, gt, lt}, 32'd0);
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         chk("idle_outputs", {27'd0, busy, done, eq, gt, lt}, 32'd0);
      end

      run("equal_a5", 8'hA5, 8'hA5, 1'b0);
      run("msb_gt", 8'h80, 8'h7F, 1'b0);
      run("captured_lt", 8'h12, 8'h13, 1'b1);

      // Abort a compare four cycles in.
      @(negedge clk);
      a     = 8'h3C;
      b     = 8'h3C;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("abort_busy_before", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("abort_outputs", {27'd0, busy, done, eq, gt, lt}, 32'd0);
      seen = 0;
      for (int n = 0; n < WIDTH + 4; n++) begin
         @(negedge clk);
         if (done || busy) seen++;
      end
      chk("abort_no_done", seen, 0);

      // Back-to-back with start held high.
      @(negedge clk);
      a     = 8'h01;
      b     = 8'h02;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      a      = 8'h02;
      b      = 8'h01;
      first  = -1;
      second = -1;
      for (int n = 0; n < 60; n++) begin
         if (n > 0) @(negedge clk);
         if (done) begin
            if (first < 0) begin
               first = n;
               chk("b2b_first_result", {29'd0, eq, gt, lt}, 32'b001);
            end else begin
               second = n;
               start  = 1'b0;
               chk("b2b_second_result", {29'd0, eq, gt, lt}, 32'b010);
               break;
            end
         end
      end
      chk("b2b_first_latency", first, exp_lat(8'h01, 8'h02));
      chk("b2b_gap", second - first, exp_lat(8'h02, 8'h01) + 1);
      repeat (3) @(negedge clk);
      chk("b2b_idle_after", {30'd0, busy, done}, 32'd0);

      for (int i = 0; i < 40; i++) begin
         x = WIDTH'($urandom);
         case ($urandom_range(0, 2))
            0:       y = WIDTH'($urandom);
            1:       y = x;
            default: y = x ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
         endcase
         run("random", x, y, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
